// File: rtl/x7seg_capture_if.sv
// Bus bundle for the 7-segment capture monitor: the scanned display lines in,
// the recovered word and status out.
interface x7seg_capture_if;
    logic [3:0]  an;
    logic [6:0]  a_to_g;
    logic [15:0] x;
    logic        frame_done;
    logic [3:0]  digit_seen;
    logic        err;

    modport master (
        output an, a_to_g,
        input  x, frame_done, digit_seen, err
    );

    modport slave (
        input  an, a_to_g,
        output x, frame_done, digit_seen, err
    );
endinterface

// File: rtl/x7seg_capture.sv
// Passive monitor of a multiplexed 4-digit 7-segment bus: deglitches each
// digit window, decodes the segments back to hex and reassembles the word.
module x7seg_capture #(
    parameter int SETTLE = 16,
    parameter int CW     = 5
) (
    input  logic            clk,
    input  logic            clr,
    x7seg_capture_if.slave  bus
);
    localparam int NUM_DIG = 4;
    localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);

    logic [3:0]  an_m, an_s;
    logic [6:0]  seg_m, seg_s;
    logic [10:0] cur, prev;
    logic [CW-1:0] cnt;
    logic        captured;
    logic        stable, cap;

    logic [NUM_DIG-1:0]       sel;
    logic                     one_hot, idle;
    logic [4:0]               dec;
    logic [NUM_DIG-1:0]       dig_wr;
    logic                     bad;
    logic [NUM_DIG-1:0][3:0]  nib;
    logic [NUM_DIG-1:0]       seen;
    logic                     frame;

    logic [15:0] x_q;
    logic        fd_q, err_q;

    // Segment code to {legal, nibble}; anything outside the hex font is illegal.
    function automatic logic [4:0] dec7(input logic [6:0] s);
        case (s)
            7'b0000001: dec7 = {1'b1, 4'h0};
            7'b1001111: dec7 = {1'b1, 4'h1};
            7'b0010010: dec7 = {1'b1, 4'h2};
            7'b0000110: dec7 = {1'b1, 4'h3};
            7'b1001100: dec7 = {1'b1, 4'h4};
            7'b0100100: dec7 = {1'b1, 4'h5};
            7'b0100000: dec7 = {1'b1, 4'h6};
            7'b0001111: dec7 = {1'b1, 4'h7};
            7'b0000000: dec7 = {1'b1, 4'h8};
            7'b0000100: dec7 = {1'b1, 4'h9};
            7'b0001000: dec7 = {1'b1, 4'hA};
            7'b1100000: dec7 = {1'b1, 4'hB};
            7'b0110001: dec7 = {1'b1, 4'hC};
            7'b1000010: dec7 = {1'b1, 4'hD};
            7'b0110000: dec7 = {1'b1, 4'hE};
            7'b0111000: dec7 = {1'b1, 4'hF};
            default:    dec7 = 5'b0_0000;
        endcase
    endfunction

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            an_m  <= 4'hF;
            an_s  <= 4'hF;
            seg_m <= 7'h7F;
            seg_s <= 7'h7F;
        end else begin
            an_m  <= bus.an;
            an_s  <= an_m;
            seg_m <= bus.a_to_g;
            seg_s <= seg_m;
        end
    end

    assign cur    = {an_s, seg_s};
    assign stable = (cur == prev);
    // Guarding with stable keeps a bus change on the terminal-count cycle from
    // being captured as if it had already settled.
    assign cap    = stable && (cnt == LAST) && !captured;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            prev     <= {4'hF, 7'h7F};
            cnt      <= '0;
            captured <= 1'b0;
        end else begin
            prev <= cur;
            if (!stable) begin
                cnt      <= '0;
                captured <= 1'b0;
            end else begin
                if (cnt != LAST)
                    cnt <= cnt + 1'b1;
                if (cap)
                    captured <= 1'b1;
            end
        end
    end

    always_comb begin
        sel     = '0;
        one_hot = 1'b1;
        case (an_s)
            4'b1110: sel = 4'b0001;
            4'b1101: sel = 4'b0010;
            4'b1011: sel = 4'b0100;
            4'b0111: sel = 4'b1000;
            default: one_hot = 1'b0;
        endcase
    end

    assign idle   = (an_s == 4'hF);
    assign dec    = dec7(seg_s);
    assign dig_wr = (cap && one_hot && dec[4]) ? sel : '0;
    assign bad    = cap && !idle && !(one_hot && dec[4]);
    assign frame  = &seen;

    // Per-digit nibble store; a capture on the frame-complete edge wins over
    // the clear so that digit starts the next frame.
    for (genvar g = 0; g < NUM_DIG; g++) begin : g_dig
        logic [3:0] nib_r;
        logic       seen_r;

        always_ff @(posedge clk or posedge clr) begin
            if (clr) begin
                nib_r  <= 4'h0;
                seen_r <= 1'b0;
            end else if (dig_wr[g]) begin
                nib_r  <= dec[3:0];
                seen_r <= 1'b1;
            end else if (frame) begin
                seen_r <= 1'b0;
            end
        end

        assign nib[g]  = nib_r;
        assign seen[g] = seen_r;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            x_q   <= 16'h0000;
            fd_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            fd_q <= frame;
            if (frame)
                x_q <= nib;
            if (bad)
                err_q <= 1'b1;
        end
    end

    assign bus.x          = x_q;
    assign bus.frame_done = fd_q;
    assign bus.digit_seen = seen;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_x7seg_capture.sv
// Directed bench for x7seg_capture: frames are queued as expected results and
// a negedge monitor checks every frame_done pulse against the queue.
module tb_x7seg_capture;
    localparam int SETTLE = 16;

    logic clk = 1'b0;
    logic clr = 1'b1;

    x7seg_capture_if bus();

    x7seg_capture #(.SETTLE(SETTLE), .CW(5)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] x;
        logic        err;
    } exp_t;

    exp_t       sbq[$];
    logic [6:0] code [16];
    int         errors = 0;
    int         checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
        bus.an     = a;
        bus.a_to_g = s;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic show(input int d, input logic [3:0] v, input int n);
        logic [3:0] a;
        a    = 4'hF;
        a[d] = 1'b0;
        drive(a, code[v], n);
    endtask

    task automatic scan(input logic [15:0] w);
        for (int i = 0; i < 4; i++)
            show(i, w[4*i +: 4], 64);
        drive(4'hF, 7'h7F, 8);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        drive(4'hF, 7'h7F, 3);
        chk("clr_err", bus.err, 0);
        chk("clr_seen", bus.digit_seen, 0);
        clr = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!clr && bus.frame_done === 1'b1) begin
            chk("frame_expected", 32'(sbq.size() != 0), 1);
            if (sbq.size() != 0) begin
                exp_t e;
                e = sbq.pop_front();
                chk("frame_x", bus.x, e.x);
                chk("frame_err", bus.err, e.err);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        code[0]  = 7'b0000001; code[1]  = 7'b1001111;
        code[2]  = 7'b0010010; code[3]  = 7'b0000110;
        code[4]  = 7'b1001100; code[5]  = 7'b0100100;
        code[6]  = 7'b0100000; code[7]  = 7'b0001111;
        code[8]  = 7'b0000000; code[9]  = 7'b0000100;
        code[10] = 7'b0001000; code[11] = 7'b1100000;
        code[12] = 7'b0110001; code[13] = 7'b1000010;
        code[14] = 7'b0110000; code[15] = 7'b0111000;
        bus.an     = 4'hF;
        bus.a_to_g = 7'h7F;

        // Reset held with the bus toggling: every output must stay at zero.
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            bus.an     = 4'($urandom);
            bus.a_to_g = 7'($urandom);
            @(negedge clk);
            chk("reset_outputs", {bus.x, bus.frame_done, bus.digit_seen, bus.err}, 0);
        end
        @(posedge clk);
        #1;
        bus.an     = 4'hF;
        bus.a_to_g = 7'h7F;
        clr        = 1'b0;
        drive(4'hF, 7'h7F, 4);

        sbq.push_back('{x: 16'h1234, err: 1'b0});
        scan(16'h1234);
        chk("err_after_1234", bus.err, 0);

        sbq.push_back('{x: 16'hBEEF, err: 1'b0});
        scan(16'hBEEF);

        // Glitch to a legal "8" shorter than SETTLE must not replace digit 0.
        sbq.push_back('{x: 16'h3217, err: 1'b0});
        show(0, 4'h7, 64);
        drive(4'b1110, 7'h00, SETTLE - 2);
        drive(4'b1110, code[7], 2);
        chk("seen_after_glitch", bus.digit_seen, 4'b0001);
        show(1, 4'h1, 64);
        show(2, 4'h2, 64);
        show(3, 4'h3, 64);
        drive(4'hF, 7'h7F, 8);
        chk("err_after_glitch", bus.err, 0);

        // Two anodes low.
        show(0, 4'hA, 64);
        chk("seen_before_an_err", bus.digit_seen, 4'b0001);
        drive(4'b1100, code[5], 64);
        chk("err_multi_anode", bus.err, 1);
        chk("seen_multi_anode", bus.digit_seen, 4'b0001);
        sbq.push_back('{x: 16'h5A5A, err: 1'b1});
        scan(16'h5A5A);

        pulse_clr();

        // Illegal segment code.
        show(0, 4'hA, 64);
        drive(4'b1110, 7'b1111110, 64);
        chk("err_bad_code", bus.err, 1);
        chk("seen_bad_code", bus.digit_seen, 4'b0001);
        sbq.push_back('{x: 16'h5A5A, err: 1'b1});
        scan(16'h5A5A);

        // Partial frame discarded by a mid-frame reset.
        show(0, 4'h2, 64);
        show(1, 4'h1, 64);
        chk("seen_partial", bus.digit_seen, 4'b0011);
        clr = 1'b1;
        drive(4'hF, 7'h7F, 3);
        chk("midreset_seen", bus.digit_seen, 0);
        chk("midreset_x", bus.x, 0);
        clr = 1'b0;
        drive(4'hF, 7'h7F, 4);
        sbq.push_back('{x: 16'h9876, err: 1'b0});
        scan(16'h9876);

        drive(4'hF, 7'h7F, 20);
        chk("x_holds", bus.x, 16'h9876);
        chk("scoreboard_drained", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
